// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: captures each result with its
// status flags in a 2-entry skid FIFO, and tracks overflow in a sticky bit
// plus a saturating counter.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic             in_overflow,
  input  logic             in_sign,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_overflow,
  output logic             out_sub,
  output logic             ovf_sticky,
  input  logic             ovf_clear,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] p_q [2];
  logic [1:0]       zero_q, neg_q, ovf_q, sub_q;
  logic             head_q, tail_q;
  logic [1:0]       occ_q, occ_d;
  logic             push, pop, ovf_push;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  // Ready depends on registered occupancy only, so no path from out_ready.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ovf_push  = push & in_overflow;

  // Occupancy next state from the push/pop pair.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Overflow tracking: an overflowing push wins over a clear in the same cycle.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (ovf_clear) begin
      ovf_sticky_d = ovf_push;
      ovf_count_d  = ovf_push ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (ovf_push) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != CntMax) ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  // FIFO pointers, occupancy and overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      occ_q        <= 2'd0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
      occ_q        <= occ_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  // Entry storage; flags are derived once, at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q[0] <= '0;
      p_q[1] <= '0;
      zero_q <= '0;
      neg_q  <= '0;
      ovf_q  <= '0;
      sub_q  <= '0;
    end else if (push) begin
      p_q[tail_q]    <= in_p;
      zero_q[tail_q] <= (in_p == '0);
      neg_q[tail_q]  <= in_sign & in_p[WIDTH-1];
      ovf_q[tail_q]  <= in_overflow;
      sub_q[tail_q]  <= in_sub;
    end
  end

  // Head presentation, forced to zero when the FIFO is empty.
  always_comb begin
    out_p        = '0;
    out_zero     = 1'b0;
    out_neg      = 1'b0;
    out_overflow = 1'b0;
    out_sub      = 1'b0;
    if (out_valid) begin
      out_p        = p_q[head_q];
      out_zero     = zero_q[head_q];
      out_neg      = neg_q[head_q];
      out_overflow = ovf_q[head_q];
      out_sub      = sub_q[head_q];
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations and a
// randomized soak.
module tb_alu_result_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_p = '0;
  logic             in_overflow = 1'b0;
  logic             in_sign = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_p;
  logic             out_zero, out_neg, out_overflow, out_sub;
  logic             ovf_sticky;
  logic             ovf_clear = 1'b0;
  logic [CNT_W-1:0] ovf_count;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
    .in_overflow(in_overflow), .in_sign(in_sign), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_zero(out_zero), .out_neg(out_neg), .out_overflow(out_overflow),
    .out_sub(out_sub), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of captured operations plus two counters.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic             ovf;
    logic             sign;
    logic             sub;
  } ent_t;

  ent_t mq[$];
  bit   m_sticky = 1'b0;
  int   m_count  = 0;
  localparam int CntMaxI = (1 << CNT_W) - 1;

  // Model update on every rising edge using the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_count  = 0;
      chk_en   = 1'b1;
    end else begin
      bit   do_push, do_pop;
      ent_t e;
      do_push = in_valid && (mq.size() < 2);
      do_pop  = (mq.size() > 0) && out_ready;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.p = in_p; e.ovf = in_overflow; e.sign = in_sign; e.sub = in_sub;
        mq.push_back(e);
      end
      if (ovf_clear) begin
        m_sticky = do_push && in_overflow;
        m_count  = (do_push && in_overflow) ? 1 : 0;
      end else if (do_push && in_overflow) begin
        m_sticky = 1'b1;
        if (m_count < CntMaxI) m_count = m_count + 1;
      end
    end
  end

  // Compare every cycle on the falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (chk_en) begin
      logic             ev, ez, en, eo, es;
      logic [WIDTH-1:0] ep;
      ev = mq.size() > 0;
      ep = '0; ez = 0; en = 0; eo = 0; es = 0;
      if (ev) begin
        ep = mq[0].p;
        ez = (mq[0].p == 0);
        en = mq[0].sign && mq[0].p[WIDTH-1];
        eo = mq[0].ovf;
        es = mq[0].sub;
      end
      check("m_out_valid", 64'(out_valid), 64'(ev));
      check("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("m_out_p", 64'(out_p), 64'(ep));
      check("m_flags", 64'({out_zero, out_neg, out_overflow, out_sub}),
            64'({ez, en, eo, es}));
      check("m_sticky", 64'(ovf_sticky), 64'(m_sticky));
      check("m_count", 64'(ovf_count), 64'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] p, input logic o,
                       input logic sg, input logic sb);
    in_valid = v; in_p = p; in_overflow = o; in_sign = sg; in_sub = sb;
  endtask

  initial begin
    // Reset and a single pass-through result.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sticky", 64'(ovf_sticky), 64'd0);
    check("rst_count", 64'(ovf_count), 64'd0);
    out_ready = 1'b1;
    drive(1, 32'h0000_00AA, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_p", 64'(out_p), 64'hAA);
    check("t1_zero_neg", 64'({out_zero, out_neg}), 64'd0);
    tick();
    check("t1_drain", 64'(out_valid), 64'd0);

    // Backpressure: fill, refused third push, in-order drain.
    out_ready = 1'b0;
    drive(1, 32'h1, 0, 0, 0); tick();
    drive(1, 32'h2, 0, 0, 1); tick();
    check("t2_full_ready", 64'(in_ready), 64'd0);
    drive(1, 32'h3, 0, 0, 0); tick();
    check("t2_still_full", 64'(in_ready), 64'd0);
    check("t2_head1", 64'(out_p), 64'h1);
    drive(0, 0, 0, 0, 0); out_ready = 1'b1; tick();
    check("t2_head2", 64'(out_p), 64'h2);
    check("t2_head2_sub", 64'(out_sub), 64'd1);
    check("t2_ready_back", 64'(in_ready), 64'd1);
    tick();
    check("t2_no_3", 64'(out_valid), 64'd0);

    // Simultaneous push and pop at occupancy 1.
    out_ready = 1'b0;
    drive(1, 32'h4, 0, 0, 0); tick();
    out_ready = 1'b1;
    drive(1, 32'h5, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    check("t3_head5", 64'(out_p), 64'h5);
    check("t3_occ1_ready", 64'(in_ready), 64'd1);
    tick();
    check("t3_empty", 64'(out_valid), 64'd0);

    // Sign and zero flags.
    drive(1, 32'h8000_0000, 0, 1, 0); tick();
    check("t4_neg_signed", 64'(out_neg), 64'd1);
    drive(1, 32'h8000_0000, 0, 0, 0); tick();
    check("t4_neg_unsigned", 64'(out_neg), 64'd0);
    drive(1, 32'h0, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0);
    check("t4_zero", 64'(out_zero), 64'd1);
    tick();

    // Overflow sticky bit and saturating counter.
    repeat (3) begin drive(1, 32'h7, 1, 1, 0); tick(); end
    drive(0, 0, 0, 0, 0);
    check("t5_sticky", 64'(ovf_sticky), 64'd1);
    check("t5_count3", 64'(ovf_count), 64'd3);
    ovf_clear = 1'b1; drive(1, 32'h9, 1, 0, 0); tick();
    ovf_clear = 1'b0; drive(0, 0, 0, 0, 0);
    check("t5_clr_set_sticky", 64'(ovf_sticky), 64'd1);
    check("t5_clr_set_count", 64'(ovf_count), 64'd1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("t5_clr_sticky", 64'(ovf_sticky), 64'd0);
    check("t5_clr_count", 64'(ovf_count), 64'd0);
    repeat (300) begin drive(1, 32'h1234, 1, 0, 1); tick(); end
    drive(0, 0, 0, 0, 0);
    check("t5_saturate", 64'(ovf_count), 64'd255);
    tick();

    // Reset while full discards entries.
    out_ready = 1'b0;
    drive(1, 32'h11, 1, 0, 0); tick();
    drive(1, 32'h22, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_ready", 64'(in_ready), 64'd1);
    check("t6_count", 64'(ovf_count), 64'd0);
    check("t6_p", 64'(out_p), 64'd0);
    out_ready = 1'b1; tick();
    check("t6_no_stale", 64'(out_valid), 64'd0);

    // Randomized soak; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] rp;
      int sel;
      sel = $urandom_range(0, 7);
      rp  = $urandom;
      if (sel == 0) rp = '0;
      if (sel == 1) rp[WIDTH-1] = 1'b1;
      drive($urandom_range(0, 3) != 0, rp, $urandom_range(0, 2) == 0,
            1'($urandom), 1'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      ovf_clear = $urandom_range(0, 19) == 0;
      rst       = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 1'b0; ovf_clear = 1'b0; drive(0, 0, 0, 0, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
